// File: rtl/disp_mode_if.sv
// disp_mode_if: button, source and display signals shared by the mode controller and its neighbours.
// Rev 1.0
`default_nettype none

interface disp_mode_if;
  logic        btn_mode;
  logic        btn_edit;
  logic [15:0] time_bcd;
  logic [15:0] alarm_bcd;
  logic [15:0] sw_bcd;
  logic [15:0] disp_data;
  logic [1:0]  view;
  logic        edit_active;
  logic [1:0]  edit_field;

  // Master drives buttons and source values; slave is the controller.
  modport master (
    output btn_mode, btn_edit, time_bcd, alarm_bcd, sw_bcd,
    input  disp_data, view, edit_active, edit_field
  );

  modport slave (
    input  btn_mode, btn_edit, time_bcd, alarm_bcd, sw_bcd,
    output disp_data, view, edit_active, edit_field
  );
endinterface

`default_nettype wire

// File: rtl/disp_mode_ctrl.sv
// disp_mode_ctrl: view/edit scheduler for the shared 4-digit BCD display bus, with field blink and idle timeout.
// Rev 1.0
`default_nettype none

module disp_mode_ctrl #(
  parameter int BLINK_HALF     = 25_000_000,
  parameter int TIMEOUT_HALVES = 20
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  disp_mode_if.slave  bus
);

  localparam int CW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam int IW = $clog2(TIMEOUT_HALVES) + 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_HALVES - 1);
  localparam logic          TGT_TIME   = 1'b0;
  localparam logic          TGT_ALARM  = 1'b1;

  typedef enum logic [2:0] {
    VIEW_TIME  = 3'd0,
    VIEW_ALARM = 3'd1,
    VIEW_SW    = 3'd2,
    EDIT_HR    = 3'd3,
    EDIT_MIN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            edit_tgt_q, edit_tgt_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [15:0]     disp_data_q, disp_data_d;
  logic [1:0]      view_q, view_d;
  logic            edit_active_q, edit_active_d;
  logic [1:0]      edit_field_q, edit_field_d;

  logic            tick;
  logic            any_btn;
  logic            timeout;
  logic            entering_edit;
  state_t          tgt_view;
  logic [15:0]     src;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= VIEW_TIME;
      edit_tgt_q    <= TGT_TIME;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      idle_cnt_q    <= '0;
      disp_data_q   <= 16'h0000;
      view_q        <= 2'd0;
      edit_active_q <= 1'b0;
      edit_field_q  <= 2'd0;
    end else begin
      state_q       <= state_d;
      edit_tgt_q    <= edit_tgt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      idle_cnt_q    <= idle_cnt_d;
      disp_data_q   <= disp_data_d;
      view_q        <= view_d;
      edit_active_q <= edit_active_d;
      edit_field_q  <= edit_field_d;
    end
  end

  // Next state: btn_edit is tested first so it wins over a simultaneous btn_mode.
  always_comb begin
    state_d    = state_q;
    edit_tgt_d = edit_tgt_q;
    tick       = (blink_cnt_q == BLINK_LAST);
    any_btn    = bus.btn_mode | bus.btn_edit;
    tgt_view   = (edit_tgt_q == TGT_ALARM) ? VIEW_ALARM : VIEW_TIME;
    timeout    = tick && !any_btn && (state_q != VIEW_TIME) && (idle_cnt_q == IDLE_LAST);

    case (state_q)
      VIEW_TIME: begin
        if (bus.btn_edit) begin
          state_d    = EDIT_HR;
          edit_tgt_d = TGT_TIME;
        end else if (bus.btn_mode) begin
          state_d = VIEW_ALARM;
        end
      end
      VIEW_ALARM: begin
        if (bus.btn_edit) begin
          state_d    = EDIT_HR;
          edit_tgt_d = TGT_ALARM;
        end else if (bus.btn_mode) begin
          state_d = VIEW_SW;
        end
      end
      VIEW_SW: begin
        if (bus.btn_mode) begin
          state_d = VIEW_TIME;
        end
      end
      EDIT_HR: begin
        if (bus.btn_edit) begin
          state_d = EDIT_MIN;
        end else if (bus.btn_mode) begin
          state_d = tgt_view;
        end
      end
      EDIT_MIN: begin
        if (any_btn) begin
          state_d = tgt_view;
        end
      end
      default: state_d = VIEW_TIME;
    endcase

    if (timeout) begin
      state_d = VIEW_TIME;
    end
  end

  // Blink and idle counters; a fresh edit field always starts in the visible phase.
  always_comb begin
    blink_cnt_d   = tick ? '0 : blink_cnt_q + CW'(1);
    blink_phase_d = tick ? ~blink_phase_q : blink_phase_q;
    entering_edit = ((state_d == EDIT_HR) || (state_d == EDIT_MIN)) && (state_d != state_q);
    if (entering_edit) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end

    idle_cnt_d = idle_cnt_q;
    if (any_btn || timeout || (state_q == VIEW_TIME)) begin
      idle_cnt_d = '0;
    end else if (tick) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end
  end

  // Output mux, registered so all four outputs move together one edge after the state.
  always_comb begin
    src           = bus.time_bcd;
    view_d        = 2'd0;
    edit_active_d = 1'b0;
    edit_field_d  = 2'd0;

    case (state_q)
      VIEW_TIME: begin
        src    = bus.time_bcd;
        view_d = 2'd0;
      end
      VIEW_ALARM: begin
        src    = bus.alarm_bcd;
        view_d = 2'd1;
      end
      VIEW_SW: begin
        src    = bus.sw_bcd;
        view_d = 2'd2;
      end
      EDIT_HR, EDIT_MIN: begin
        src           = (edit_tgt_q == TGT_ALARM) ? bus.alarm_bcd : bus.time_bcd;
        view_d        = {1'b0, edit_tgt_q};
        edit_active_d = 1'b1;
        edit_field_d  = (state_q == EDIT_HR) ? 2'd1 : 2'd2;
      end
      default: begin
        src    = bus.time_bcd;
        view_d = 2'd0;
      end
    endcase

    disp_data_d = src;
    if (blink_phase_q && (state_q == EDIT_HR)) begin
      disp_data_d[15:8] = 8'hFF;
    end
    if (blink_phase_q && (state_q == EDIT_MIN)) begin
      disp_data_d[7:0] = 8'hFF;
    end
  end

  assign bus.disp_data   = disp_data_q;
  assign bus.view        = view_q;
  assign bus.edit_active = edit_active_q;
  assign bus.edit_field  = edit_field_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_mode_ctrl.sv
// tb_disp_mode_ctrl: directed vector table plus hand-written corner sequences for disp_mode_ctrl.
// Rev 1.0
`default_nettype none

module tb_disp_mode_ctrl;

  logic clk;
  logic sys_rst_n;
  int   tests;
  int   fails;

  disp_mode_if bus ();

  disp_mode_ctrl #(
    .BLINK_HALF     (4),
    .TIMEOUT_HALVES (3)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        edit;
    logic [15:0] disp;
    logic [1:0]  view;
    logic        ea;
    logic [1:0]  field;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, input logic e, input logic [15:0] d,
                     input logic [1:0] v, input logic a, input logic [1:0] f);
    vec_t t;
    t.mode = m; t.edit = e; t.disp = d; t.view = v; t.ea = a; t.field = f;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [15:0] d, input logic [1:0] v,
                       input logic a, input logic [1:0] f);
    tests++;
    if (bus.disp_data !== d || bus.view !== v || bus.edit_active !== a || bus.edit_field !== f) begin
      fails++;
      $display("FAIL %s: got disp=%h view=%0d ea=%0d field=%0d, want disp=%h view=%0d ea=%0d field=%0d",
               name, bus.disp_data, bus.view, bus.edit_active, bus.edit_field, d, v, a, f);
    end
  endtask

  // Buttons are sampled on the next rising edge; outputs are looked at 1 ns after it.
  task automatic step(input logic m, input logic e);
    bus.btn_mode = m;
    bus.btn_edit = e;
    @(posedge clk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_edit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sys_rst_n    = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_edit = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    sys_rst_n     = 1'b0;
    bus.btn_mode  = 1'b0;
    bus.btn_edit  = 1'b0;
    bus.time_bcd  = 16'h1234;
    bus.alarm_bcd = 16'h0630;
    bus.sw_bcd    = 16'h0059;

    // Edge-by-edge table: the buttons of entry k show up in the outputs of entry k+1.
    add(0,0,16'h1234,0,0,0); add(0,0,16'h1234,0,0,0);
    add(1,0,16'h1234,0,0,0); add(0,0,16'h0630,1,0,0);
    add(1,0,16'h0630,1,0,0); add(0,0,16'h0059,2,0,0);
    add(1,0,16'h0059,2,0,0); add(0,0,16'h1234,0,0,0);
    add(0,1,16'h1234,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0,16'h1234,0,1,1);
    for (int i = 0; i < 4; i++) add(0,0,16'hFF34,0,1,1);
    add(0,0,16'h1234,0,1,1);
    add(0,1,16'h1234,0,1,1);
    for (int i = 0; i < 4; i++) add(0,0,16'h1234,0,1,2);
    for (int i = 0; i < 4; i++) add(0,0,16'h12FF,0,1,2);
    add(0,1,16'h1234,0,1,2);
    add(0,0,16'h1234,0,0,0); add(0,0,16'h1234,0,0,0);

    do_reset();
    check("reset_state", 16'h0000, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].mode, vecs[i].edit);
      check($sformatf("vec%0d", i), vecs[i].disp, vecs[i].view, vecs[i].ea, vecs[i].field);
    end

    // Alarm view idles out exactly on the third blink tick (edge 12).
    do_reset();
    step(1, 0);
    for (int e = 2; e <= 12; e++) begin
      step(0, 0);
      check($sformatf("idle_alarm_e%0d", e), 16'h0630, 1, 0, 0);
    end
    step(0, 0);
    check("timeout_to_time", 16'h1234, 0, 0, 0);

    // A pulse on the timeout tick suppresses the timeout.
    do_reset();
    step(1, 0);
    for (int e = 2; e <= 11; e++) step(0, 0);
    step(0, 1);
    check("pulse_on_tick_pre", 16'h0630, 1, 0, 0);
    step(0, 0);
    check("pulse_on_tick_post", 16'h0630, 1, 1, 1);

    // Simultaneous buttons: edit wins in time view, mode acts in stopwatch view.
    do_reset();
    step(1, 1);
    step(0, 0);
    check("both_in_time", 16'h1234, 0, 1, 1);
    do_reset();
    step(1, 0);
    step(1, 0);
    check("to_sw_pre", 16'h0630, 1, 0, 0);
    step(1, 1);
    check("both_in_sw_pre", 16'h0059, 2, 0, 0);
    step(0, 0);
    check("both_in_sw_post", 16'h1234, 0, 0, 0);

    // Asynchronous reset during the blank phase of minute edit.
    do_reset();
    step(0, 1);
    step(0, 1);
    for (int e = 3; e <= 6; e++) step(0, 0);
    check("edit_min_visible", 16'h1234, 0, 1, 2);
    step(0, 0);
    check("edit_min_blank", 16'h12FF, 0, 1, 2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_reset", 16'h0000, 0, 0, 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    step(0, 0);
    check("after_reset", 16'h1234, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
